// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite register slice: response codes and
// the per-channel skid-buffer state encoding.
package axil_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bus bundle. s_axil is the view of a block that receives requests;
// m_axil is the view of a block that issues them.
interface axil_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport s_axil (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport m_axil (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );
endinterface

// File: rtl/axil_skid_buffer.sv
// Two-entry skid buffer: valid, payload and ready all come from flops, so no
// combinational path crosses the buffer in either direction.
module axil_skid_buffer
    import axil_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             in_hs, out_hs;

    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a value held, which would infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        in_hs   = in_valid && ready_q;
        out_hs  = valid_q && out_ready;

        unique case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    main_d = in_data;
                end else if (in_hs) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Ready is low here, so only the drain side can move.
                if (out_hs) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        valid_d = (state_d != EMPTY);
        ready_d = (state_d != FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of statement order.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            // NOTE: the payload registers are cleared too, so the bus shows
            // zeros rather than stale data while the slice is held in reset.
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/axil_register_slice.sv
// AXI-Lite register slice: one independent skid buffer per channel, forward
// for AW/W/AR and reverse for B/R.
module axil_register_slice
    import axil_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input logic   aclk,
    input logic   areset,
    axil_if.s_axil s_axil,
    axil_if.m_axil m_axil
);
    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int W_WIDTH    = AXI_DATA_WIDTH + STRB_WIDTH;
    localparam int R_WIDTH    = AXI_DATA_WIDTH + 2;

    logic [W_WIDTH-1:0] w_out;
    logic [R_WIDTH-1:0] r_out;

    axil_skid_buffer #(.WIDTH(AXI_ADDR_WIDTH)) u_aw (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (s_axil.awvalid),
        .in_ready  (s_axil.awready),
        .in_data   (s_axil.awaddr),
        .out_valid (m_axil.awvalid),
        .out_ready (m_axil.awready),
        .out_data  (m_axil.awaddr)
    );

    axil_skid_buffer #(.WIDTH(W_WIDTH)) u_w (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (s_axil.wvalid),
        .in_ready  (s_axil.wready),
        .in_data   ({s_axil.wdata, s_axil.wstrb}),
        .out_valid (m_axil.wvalid),
        .out_ready (m_axil.wready),
        .out_data  (w_out)
    );
    assign {m_axil.wdata, m_axil.wstrb} = w_out;

    axil_skid_buffer #(.WIDTH(2)) u_b (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (m_axil.bvalid),
        .in_ready  (m_axil.bready),
        .in_data   (m_axil.bresp),
        .out_valid (s_axil.bvalid),
        .out_ready (s_axil.bready),
        .out_data  (s_axil.bresp)
    );

    axil_skid_buffer #(.WIDTH(AXI_ADDR_WIDTH)) u_ar (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (s_axil.arvalid),
        .in_ready  (s_axil.arready),
        .in_data   (s_axil.araddr),
        .out_valid (m_axil.arvalid),
        .out_ready (m_axil.arready),
        .out_data  (m_axil.araddr)
    );

    axil_skid_buffer #(.WIDTH(R_WIDTH)) u_r (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (m_axil.rvalid),
        .in_ready  (m_axil.rready),
        .in_data   ({m_axil.rdata, m_axil.rresp}),
        .out_valid (s_axil.rvalid),
        .out_ready (s_axil.rready),
        .out_data  (r_out)
    );
    assign {s_axil.rdata, s_axil.rresp} = r_out;

endmodule

// File: tb/tb_axil_register_slice.sv
// Directed and randomised bench for axil_register_slice: reset values, latency,
// stall/skid behaviour, streaming, reset discard, channel independence.
module tb_axil_register_slice;
    import axil_pkg::*;

    typedef logic [35:0] beat_t;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_addr;
        logic        out_ready;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_addr;
    } ar_vec_t;

    logic aclk = 1'b0;
    logic areset;
    int   n_checks = 0;
    int   n_errors = 0;

    axil_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) s_if ();
    axil_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) m_if ();

    axil_register_slice #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
        .aclk   (aclk),
        .areset (areset),
        .s_axil (s_if),
        .m_axil (m_if)
    );

    always #5 aclk = ~aclk;

    // Per-channel arrays for the random phase: 0=AW 1=W 2=B 3=AR 4=R.
    logic  dv [5];
    beat_t dd [5];
    logic  dr [5];
    logic  ir [5];
    logic  ov [5];
    beat_t od [5];
    logic  stall [5];
    beat_t held [5];
    logic  hs_in [5];
    beat_t sb_q [5][$];
    string ch_name [5] = '{"aw", "w", "b", "ar", "r"};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic idle_all();
        s_if.awvalid = 1'b0; s_if.awaddr = '0;
        s_if.wvalid  = 1'b0; s_if.wdata  = '0; s_if.wstrb = '0;
        s_if.bready  = 1'b0;
        s_if.arvalid = 1'b0; s_if.araddr = '0;
        s_if.rready  = 1'b0;
        m_if.awready = 1'b0;
        m_if.wready  = 1'b0;
        m_if.bvalid  = 1'b0; m_if.bresp = '0;
        m_if.arready = 1'b0;
        m_if.rvalid  = 1'b0; m_if.rdata = '0; m_if.rresp = '0;
    endtask

    task automatic do_reset();
        idle_all();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
        step();
    endtask

    function automatic logic [4:0] all_readies();
        return {s_if.awready, s_if.wready, m_if.bready, s_if.arready, m_if.rready};
    endfunction

    function automatic logic [4:0] all_valids();
        return {m_if.awvalid, m_if.wvalid, s_if.bvalid, m_if.arvalid, s_if.rvalid};
    endfunction

    function automatic beat_t rand_beat(input int c);
        beat_t b;
        b = beat_t'({$urandom(), $urandom()});
        case (c)
            0, 3:    b = b & 36'h0_FFFF_FFFF;
            2:       b = b & 36'h0_0000_0003;
            4:       b = b & 36'h3_FFFF_FFFF;
            default: b = b;
        endcase
        return b;
    endfunction

    task automatic apply_drive();
        s_if.awvalid = dv[0]; s_if.awaddr = dd[0][31:0]; m_if.awready = dr[0];
        s_if.wvalid  = dv[1]; {s_if.wdata, s_if.wstrb} = dd[1]; m_if.wready = dr[1];
        m_if.bvalid  = dv[2]; m_if.bresp = dd[2][1:0]; s_if.bready = dr[2];
        s_if.arvalid = dv[3]; s_if.araddr = dd[3][31:0]; m_if.arready = dr[3];
        m_if.rvalid  = dv[4]; {m_if.rdata, m_if.rresp} = dd[4][33:0]; s_if.rready = dr[4];
    endtask

    task automatic sample();
        ir[0] = s_if.awready; ov[0] = s_if.awvalid & 1'b0 | m_if.awvalid; od[0] = {4'b0, m_if.awaddr};
        ir[1] = s_if.wready;  ov[1] = m_if.wvalid;  od[1] = {m_if.wdata, m_if.wstrb};
        ir[2] = m_if.bready;  ov[2] = s_if.bvalid;  od[2] = {34'b0, s_if.bresp};
        ir[3] = s_if.arready; ov[3] = m_if.arvalid; od[3] = {4'b0, m_if.araddr};
        ir[4] = m_if.rready;  ov[4] = s_if.rvalid;  od[4] = {2'b0, s_if.rdata, s_if.rresp};
    endtask

    task automatic random_phase(input int cycles, input int drain_cycles);
        for (int c = 0; c < 5; c++) begin
            dv[c] = 1'b0; dd[c] = '0; dr[c] = 1'b0;
            stall[c] = 1'b0; held[c] = '0; hs_in[c] = 1'b0;
            sb_q[c].delete();
        end
        for (int cyc = 0; cyc < cycles + drain_cycles; cyc++) begin
            sample();
            for (int c = 0; c < 5; c++) begin
                if (stall[c])
                    check($sformatf("stable_%s", ch_name[c]), 64'({ov[c], od[c]}), 64'({1'b1, held[c]}));
                if (!dv[c] || hs_in[c]) begin
                    dv[c] = (cyc < cycles) && ($urandom_range(0, 99) < 60);
                    dd[c] = rand_beat(c);
                end
                dr[c] = (cyc >= cycles) || ($urandom_range(0, 99) < 55);
            end
            apply_drive();
            for (int c = 0; c < 5; c++) begin
                hs_in[c] = dv[c] && ir[c];
                if (hs_in[c]) sb_q[c].push_back(dd[c]);
                if (ov[c] && dr[c]) begin
                    if (sb_q[c].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_%s: got unexpected beat %h, expected none", ch_name[c], od[c]);
                    end else begin
                        check($sformatf("sb_%s", ch_name[c]), 64'(od[c]), 64'(sb_q[c].pop_front()));
                    end
                end
                stall[c] = ov[c] && !dr[c];
                held[c]  = od[c];
            end
            step();
        end
        for (int c = 0; c < 5; c++)
            check($sformatf("drained_%s", ch_name[c]), 64'(sb_q[c].size()), 64'd0);
    endtask

    initial begin
        ar_vec_t ar_tbl [6];
        int      seen;

        ar_tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10};
        ar_tbl[1] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h10};
        ar_tbl[2] = '{1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 32'h10};
        ar_tbl[3] = '{1'b1, 32'h30, 1'b1, 1'b1, 1'b1, 32'h20};
        ar_tbl[4] = '{1'b1, 32'h30, 1'b1, 1'b1, 1'b1, 32'h30};
        ar_tbl[5] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h30};

        // Reset values, then readies one edge after release.
        idle_all();
        areset = 1'b1;
        @(negedge aclk);
        step();
        step();
        check("rst_valids", 64'(all_valids()), 64'd0);
        check("rst_readies", 64'(all_readies()), 64'd0);
        check("rst_payload", 64'({m_if.awaddr, m_if.wdata}), 64'd0);
        check("rst_payload_r", 64'({s_if.rdata, s_if.bresp}), 64'd0);
        areset = 1'b0;
        check("rst_release_readies_low", 64'(all_readies()), 64'd0);
        step();
        check("post_rst_readies", 64'(all_readies()), 64'h1F);
        check("post_rst_valids", 64'(all_valids()), 64'd0);

        // Single write with 1-cycle latency and B return.
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h0000_1000;
        s_if.wvalid  = 1'b1; s_if.wdata  = 32'hDEAD_BEEF; s_if.wstrb = 4'hF;
        m_if.awready = 1'b1; m_if.wready = 1'b1; s_if.bready = 1'b1;
        step();
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
        check("wr_aw", 64'({m_if.awvalid, m_if.awaddr}), 64'({1'b1, 32'h0000_1000}));
        check("wr_w", 64'({m_if.wvalid, m_if.wdata, m_if.wstrb}), 64'({1'b1, 32'hDEAD_BEEF, 4'hF}));
        step();
        check("wr_drained", 64'({m_if.awvalid, m_if.wvalid}), 64'd0);
        m_if.bvalid = 1'b1; m_if.bresp = OKAY;
        step();
        m_if.bvalid = 1'b0;
        check("wr_b", 64'({s_if.bvalid, s_if.bresp}), 64'({1'b1, OKAY}));
        step();
        check("wr_b_done", 64'(s_if.bvalid), 64'd0);

        // AR stall: two accepted, ready drops, ordered drain.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            s_if.arvalid = ar_tbl[i].in_valid;
            s_if.araddr  = ar_tbl[i].in_addr;
            m_if.arready = ar_tbl[i].out_ready;
            step();
            check($sformatf("ar_tbl%0d_ready", i), 64'(s_if.arready), 64'(ar_tbl[i].exp_ready));
            check($sformatf("ar_tbl%0d_valid", i), 64'(m_if.arvalid), 64'(ar_tbl[i].exp_valid));
            check($sformatf("ar_tbl%0d_addr", i), 64'(m_if.araddr), 64'(ar_tbl[i].exp_addr));
        end

        // Streaming: 100 R beats in 100 cycles, no gaps.
        do_reset();
        s_if.rready = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            if (i > 0)
                check($sformatf("stream_%0d", i - 1), 64'({m_if.rready, s_if.rvalid, s_if.rdata}),
                      64'({1'b1, 1'b1, 32'(i - 1)}));
            m_if.rvalid = (i < 100);
            m_if.rdata  = 32'(i);
            m_if.rresp  = OKAY;
            step();
        end
        check("stream_end", 64'(s_if.rvalid), 64'd0);

        // Reset while W is FULL: both beats discarded.
        do_reset();
        s_if.wvalid = 1'b1; s_if.wdata = 32'hAAAA_0001; s_if.wstrb = 4'h1;
        step();
        s_if.wdata = 32'hBBBB_0002; s_if.wstrb = 4'h2;
        step();
        s_if.wvalid = 1'b0;
        check("wfull_ready", 64'({s_if.wready, m_if.wvalid, m_if.wdata}), 64'({1'b0, 1'b1, 32'hAAAA_0001}));
        areset = 1'b1;
        step();
        areset = 1'b0;
        m_if.wready = 1'b1;
        check("midrst_valids", 64'(all_valids()), 64'd0);
        step();
        check("midrst_readies", 64'(all_readies()), 64'h1F);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_if.wvalid) seen++;
            step();
        end
        check("midrst_no_beats", 64'(seen), 64'd0);

        // Independence: W early, AW late, B stalled while AR/R flow.
        do_reset();
        m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
        s_if.rready  = 1'b1; s_if.bready = 1'b0;
        s_if.wvalid = 1'b1; s_if.wdata = 32'h1234_5678; s_if.wstrb = 4'h3;
        step();
        s_if.wvalid = 1'b0;
        check("ind_w", 64'({m_if.wvalid, m_if.wdata, m_if.wstrb}), 64'({1'b1, 32'h1234_5678, 4'h3}));
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (m_if.awvalid) seen++;
        end
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h0000_2000;
        step();
        s_if.awvalid = 1'b0;
        check("ind_aw_early", 64'(seen), 64'd0);
        check("ind_aw", 64'({m_if.awvalid, m_if.awaddr}), 64'({1'b1, 32'h0000_2000}));
        m_if.bvalid = 1'b1; m_if.bresp = SLVERR;
        step();
        m_if.bresp = DECERR;
        step();
        m_if.bvalid = 1'b0;
        check("ind_b_full", 64'({m_if.bready, s_if.bvalid, s_if.bresp}), 64'({1'b0, 1'b1, SLVERR}));
        s_if.arvalid = 1'b1; s_if.araddr = 32'h0000_0044;
        step();
        s_if.arvalid = 1'b0;
        check("ind_ar", 64'({m_if.arvalid, m_if.araddr}), 64'({1'b1, 32'h0000_0044}));
        m_if.rvalid = 1'b1; m_if.rdata = 32'h0000_CAFE; m_if.rresp = OKAY;
        step();
        m_if.rvalid = 1'b0;
        check("ind_r", 64'({s_if.rvalid, s_if.rdata, s_if.rresp}), 64'({1'b1, 32'h0000_CAFE, OKAY}));
        s_if.bready = 1'b1;
        step();
        check("ind_b_skid", 64'({s_if.bvalid, s_if.bresp}), 64'({1'b1, DECERR}));
        step();
        check("ind_b_done", 64'(s_if.bvalid), 64'd0);

        // Random traffic and backpressure on all channels with scoreboards.
        do_reset();
        random_phase(3000, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
